// File: rtl/ntr_host_ctrl_pkg.sv
// ntr_host_ctrl_pkg: shared constants, FSM state encoding and a byte helper
// for the NTR (DS card bus) host-side initiator.
package ntr_host_ctrl_pkg;

  // Number of bytes in an NTR command word.
  localparam int NTR_CMD_BYTES = 8;

  // Bus idle levels: clock parks high, chip select is inactive (high).
  localparam logic NTR_IDLE_CLK = 1'b1;
  localparam logic NTR_IDLE_CS  = 1'b1;

  // Host FSM states. ST_TURN is only entered when the turnaround gap is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_CMD_LO = 3'd2,
    ST_CMD_HI = 3'd3,
    ST_RSP_LO = 3'd4,
    ST_RSP_HI = 3'd5,
    ST_END    = 3'd6,
    ST_TURN   = 3'd7
  } ntr_state_e;

  // Byte that goes out next: the command register shifts left, so it is always the top byte.
  function automatic logic [7:0] ntr_lead_byte(input logic [63:0] v);
    return v[63:56];
  endfunction

endpackage

// File: rtl/ntr_host_ctrl_if.sv
// ntr_host_ctrl_if: NTR card-bus pins. The host drives clock, chip select and
// command data; the card drives the response data.
interface ntr_host_ctrl_if;
  logic       ntr_clk;
  logic       ntr_cs1;
  logic [7:0] ntr_data_out;
  logic       ntr_data_oe;
  logic [7:0] ntr_data_in;

  modport master (
    output ntr_clk,
    output ntr_cs1,
    output ntr_data_out,
    output ntr_data_oe,
    input  ntr_data_in
  );

  modport slave (
    input  ntr_clk,
    input  ntr_cs1,
    input  ntr_data_out,
    input  ntr_data_oe,
    output ntr_data_in
  );
endinterface

// File: rtl/ntr_host_ctrl_phase_timer.sv
// ntr_host_ctrl_phase_timer: loadable down-counter that measures one bus phase
// of CLK_DIV clk cycles. 'load' restarts the phase; 'expire' is high in the
// last cycle of the phase, so the owner changes state on that edge.
module ntr_host_ctrl_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on phase start, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/ntr_host_ctrl.sv
// ntr_host_ctrl: NTR host-side initiator. Drops chip select, clocks out an
// 8-byte command (MSB byte first, data stable through each high phase), then
// clocks in resp_len response bytes, capturing on each rising ntr_clk.
// Optional macro NTR_TURNAROUND_EN: inserts a 2*CLK_DIV high-clock gap with
// the data driver off between command and response (only when resp_len != 0).
module ntr_host_ctrl
  import ntr_host_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,   // clk cycles per ntr_clk half-period, >= 1
  parameter int RESP_LEN_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [63:0]           cmd_data,
  input  logic [RESP_LEN_W-1:0] resp_len,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  ntr_host_ctrl_if.master       bus
);

  ntr_state_e            state_q, state_d;
  logic [63:0]           cmd_q, cmd_d;
  logic [2:0]            idx_q, idx_d;
  logic [RESP_LEN_W-1:0] left_q, left_d;
  logic                  turn_half_q, turn_half_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ntr_clk_q, ntr_clk_d;
  logic                  ntr_cs1_q, ntr_cs1_d;
  logic [7:0]            dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tmr_load_s;
  logic                  tmr_expire_s;

  ntr_host_ctrl_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load_s),
    .expire (tmr_expire_s)
  );

  // Next-state and next-output logic; every phase change reloads the timer.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    left_d      = left_q;
    turn_half_d = turn_half_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ntr_clk_d   = ntr_clk_q;
    ntr_cs1_d   = ntr_cs1_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tmr_load_s  = 1'b0;

    case (state_q)
      ST_IDLE, ST_END: begin
        // The done cycle (ST_END) already reports busy=0, so start is honoured there too.
        if (start) begin
          state_d    = ST_SETUP;
          cmd_d      = cmd_data;
          left_d     = resp_len;
          idx_d      = 3'd0;
          busy_d     = 1'b1;
          ntr_cs1_d  = 1'b0;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (tmr_expire_s) begin
          state_d    = ST_CMD_LO;
          ntr_clk_d  = 1'b0;
          dout_d     = ntr_lead_byte(cmd_q);
          cmd_d      = {cmd_q[55:0], 8'h00};
          oe_d       = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_SETUP;
        end
      end

      ST_CMD_LO: begin
        if (tmr_expire_s) begin
          state_d    = ST_CMD_HI;
          ntr_clk_d  = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_CMD_LO;
        end
      end

      ST_CMD_HI: begin
        if (tmr_expire_s) begin
          if (idx_q == 3'(NTR_CMD_BYTES - 1)) begin
            oe_d   = 1'b0;
            dout_d = 8'h00;
            if (left_q == {RESP_LEN_W{1'b0}}) begin
              state_d   = ST_END;
              ntr_cs1_d = NTR_IDLE_CS;
              busy_d    = 1'b0;
              done_d    = 1'b1;
            end else begin
`ifdef NTR_TURNAROUND_EN
              // Clock stays high with the driver off while the card turns the bus around.
              state_d     = ST_TURN;
              turn_half_d = 1'b0;
              tmr_load_s  = 1'b1;
`else
              state_d    = ST_RSP_LO;
              ntr_clk_d  = 1'b0;
              tmr_load_s = 1'b1;
`endif
            end
          end else begin
            state_d    = ST_CMD_LO;
            idx_d      = idx_q + 3'd1;
            ntr_clk_d  = 1'b0;
            dout_d     = ntr_lead_byte(cmd_q);
            cmd_d      = {cmd_q[55:0], 8'h00};
            tmr_load_s = 1'b1;
          end
        end else begin
          state_d = ST_CMD_HI;
        end
      end

      ST_TURN: begin
        // Two timer phases of CLK_DIV make up the 2*CLK_DIV gap.
        if (tmr_expire_s) begin
          if (turn_half_q) begin
            state_d    = ST_RSP_LO;
            ntr_clk_d  = 1'b0;
            tmr_load_s = 1'b1;
          end else begin
            turn_half_d = 1'b1;
            tmr_load_s  = 1'b1;
          end
        end else begin
          state_d = ST_TURN;
        end
      end

      ST_RSP_LO: begin
        if (tmr_expire_s) begin
          state_d    = ST_RSP_HI;
          ntr_clk_d  = 1'b1;
          rx_data_d  = bus.ntr_data_in;
          rx_valid_d = 1'b1;
          left_d     = left_q - RESP_LEN_W'(1'b1);
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_RSP_LO;
        end
      end

      ST_RSP_HI: begin
        if (tmr_expire_s) begin
          if (left_q == {RESP_LEN_W{1'b0}}) begin
            state_d   = ST_END;
            ntr_cs1_d = NTR_IDLE_CS;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d    = ST_RSP_LO;
            ntr_clk_d  = 1'b0;
            tmr_load_s = 1'b1;
          end
        end else begin
          state_d = ST_RSP_HI;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset to bus-idle values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 64'h0;
      idx_q       <= 3'd0;
      left_q      <= {RESP_LEN_W{1'b0}};
      turn_half_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ntr_clk_q   <= NTR_IDLE_CLK;
      ntr_cs1_q   <= NTR_IDLE_CS;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      left_q      <= left_d;
      turn_half_q <= turn_half_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ntr_clk_q   <= ntr_clk_d;
      ntr_cs1_q   <= ntr_cs1_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign rx_data          = rx_data_q;
  assign rx_valid         = rx_valid_q;
  assign bus.ntr_clk      = ntr_clk_q;
  assign bus.ntr_cs1      = ntr_cs1_q;
  assign bus.ntr_data_out = dout_q;
  assign bus.ntr_data_oe  = oe_q;

endmodule

// File: tb/tb_ntr_host_ctrl.sv
// tb_ntr_host_ctrl: directed bench for ntr_host_ctrl. dut0 runs CLK_DIV=2,
// dut1 runs CLK_DIV=1; the bench plays the card on both buses.
module tb_ntr_host_ctrl;

`ifdef NTR_TURNAROUND_EN
  localparam int TA = 2;
`else
  localparam int TA = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic [63:0] cmd0, cmd1;
  logic [11:0] len0, len1;
  logic        busy0, done0, rxv0, busy1, done1, rxv1;
  logic [7:0]  rxd0, rxd1;

  ntr_host_ctrl_if bus0();
  ntr_host_ctrl_if bus1();

  ntr_host_ctrl #(.CLK_DIV(2), .RESP_LEN_W(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cmd_data(cmd0), .resp_len(len0),
    .busy(busy0), .done(done0), .rx_data(rxd0), .rx_valid(rxv0), .bus(bus0)
  );

  ntr_host_ctrl #(.CLK_DIV(1), .RESP_LEN_W(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmd_data(cmd1), .resp_len(len1),
    .busy(busy1), .done(done1), .rx_data(rxd1), .rx_valid(rxv1), .bus(bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Capture results of the last dut0 transaction (offsets are clk edges after E0).
  logic [7:0] got_bytes[$];
  int         rise_at[$];
  int         rx_at[$];
  logic [7:0] rx_got[$];
  logic [7:0] resp_pat[$];
  int         done_at, done_cnt, cs1_at;

  // Capture results of the last dut1 transaction.
  int         fall1_at, rx1_first, rx1_cnt, done1_at, done1_cnt;
  logic [7:0] rx1_first_d, rx1_last_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a dut0 transaction and act as the card until a few cycles after done.
  task automatic run_txn(input logic [63:0] cmd, input logic [11:0] len,
                         input int repulse_at, input logic [63:0] alt);
    logic prev_clk;
    int   ri;
    got_bytes.delete(); rise_at.delete(); rx_at.delete(); rx_got.delete();
    done_at = -1; done_cnt = 0; cs1_at = -1; prev_clk = 1'b1; ri = 0;
    cmd0 = cmd; len0 = len; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      if (bus0.ntr_clk && !prev_clk && bus0.ntr_data_oe) begin
        got_bytes.push_back(bus0.ntr_data_out);
        rise_at.push_back(n);
      end
      if (!bus0.ntr_clk && prev_clk && !bus0.ntr_data_oe) begin
        bus0.ntr_data_in = (ri < resp_pat.size()) ? resp_pat[ri] : 8'hEE;
        ri++;
      end
      if (rxv0) begin rx_at.push_back(n); rx_got.push_back(rxd0); end
      if (done0) begin done_cnt++; if (done_at < 0) done_at = n; end
      if (bus0.ntr_cs1 && cs1_at < 0) cs1_at = n;
      prev_clk = bus0.ntr_clk;
      start0 = (n == repulse_at);
      cmd0   = (n == repulse_at) ? alt : cmd;
      if (done_at >= 0 && n >= done_at + 4) break;
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  // Start a dut1 transaction; the card answers 3C, 3D, 3E, ... one per clock fall.
  task automatic run_txn1(input logic [11:0] len, input int budget);
    logic       prev_clk;
    logic [7:0] fcnt;
    fall1_at = -1; rx1_first = -1; rx1_cnt = 0; done1_at = -1; done1_cnt = 0;
    rx1_first_d = 8'h00; rx1_last_d = 8'h00; prev_clk = 1'b1; fcnt = 8'h00;
    cmd1 = 64'h9F00000000000000; len1 = len; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (!bus1.ntr_clk && prev_clk && !bus1.ntr_data_oe) begin
        if (fall1_at < 0) fall1_at = n;
        bus1.ntr_data_in = 8'h3C + fcnt;
        fcnt++;
      end
      if (rxv1) begin
        if (rx1_first < 0) begin rx1_first = n; rx1_first_d = rxd1; end
        rx1_last_d = rxd1;
        rx1_cnt++;
      end
      if (done1) begin done1_cnt++; if (done1_at < 0) done1_at = n; end
      prev_clk = bus1.ntr_clk;
      if (done1_at >= 0 && n >= done1_at + 4) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    cmd0 = 64'h0; cmd1 = 64'h0; len0 = 12'd0; len1 = 12'd0;
    bus0.ntr_data_in = 8'h00; bus1.ntr_data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy0, done0, bus0.ntr_clk, bus0.ntr_cs1, bus0.ntr_data_oe, rxv0} !== 6'b001100) begin
      n_fail++;
      $display("FAIL reset_ctl0: got busy,done,clk,cs1,oe,rxv=%b want 001100",
               {busy0, done0, bus0.ntr_clk, bus0.ntr_cs1, bus0.ntr_data_oe, rxv0});
    end
    n_checks++;
    if ({bus0.ntr_data_out, rxd0} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data0: got data_out,rx_data=%h want 0000", {bus0.ntr_data_out, rxd0});
    end
    n_checks++;
    if ({busy1, done1, bus1.ntr_clk, bus1.ntr_cs1, bus1.ntr_data_oe} !== 5'b00110) begin
      n_fail++;
      $display("FAIL reset_ctl1: got %b want 00110",
               {busy1, done1, bus1.ntr_clk, bus1.ntr_cs1, bus1.ntr_data_oe});
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({busy0, done0, bus0.ntr_clk, bus0.ntr_cs1, bus0.ntr_data_oe} !== 5'b00110) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL idle_hold: got %0d bad idle cycles want 0", bad);
    end
  endtask

  task automatic test_cmd_only();
    logic [63:0] exp_cmd;
    logic [7:0]  g;
    exp_cmd = 64'hFF00000000000001;
    resp_pat.delete();
    run_txn(exp_cmd, 12'd0, -1, 64'h0);
    n_checks++;
    if (got_bytes.size() !== 8) begin
      n_fail++; $display("FAIL cmd_count: got %0d bytes want 8", got_bytes.size());
    end
    for (int i = 0; i < 8; i++) begin
      g = (i < got_bytes.size()) ? got_bytes[i] : 8'hxx;
      n_checks++;
      if (g !== exp_cmd[63-8*i -: 8]) begin
        n_fail++; $display("FAIL cmd_byte%0d: got %h want %h", i, g, exp_cmd[63-8*i -: 8]);
      end
    end
    n_checks++;
    if (rise_at.size() != 8 || rise_at[0] !== 4 || rise_at[7] !== 32) begin
      n_fail++; $display("FAIL cmd_rise_timing: got first/last rise %0d/%0d want 4/32",
                         (rise_at.size() > 0) ? rise_at[0] : -1,
                         (rise_at.size() == 8) ? rise_at[7] : -1);
    end
    n_checks++;
    if (done_at !== 34 || cs1_at !== 34 || done_cnt !== 1) begin
      n_fail++; $display("FAIL cmd_done: got done_at=%0d cs1_at=%0d count=%0d want 34 34 1",
                         done_at, cs1_at, done_cnt);
    end
    n_checks++;
    if (rx_at.size() !== 0 || busy0 !== 1'b0 || bus0.ntr_clk !== 1'b1) begin
      n_fail++; $display("FAIL cmd_tail: got rx=%0d busy=%b clk=%b want 0 0 1",
                         rx_at.size(), busy0, bus0.ntr_clk);
    end
  endtask

  task automatic test_resp();
    logic [7:0] exp_d[3];
    int         exp_t[3];
    exp_d = '{8'hA5, 8'h5A, 8'hC3};
    exp_t = '{36, 40, 44};
    resp_pat.delete();
    resp_pat.push_back(8'hA5); resp_pat.push_back(8'h5A); resp_pat.push_back(8'hC3);
    run_txn(64'hFF00000000000001, 12'd3, -1, 64'h0);
    n_checks++;
    if (rx_at.size() !== 3 || got_bytes.size() !== 8) begin
      n_fail++; $display("FAIL resp_count: got rx=%0d cmd=%0d want 3 8", rx_at.size(), got_bytes.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= rx_at.size() || rx_got[i] !== exp_d[i] || rx_at[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL resp_byte%0d: got %h at %0d want %h at %0d", i,
                           (i < rx_got.size()) ? rx_got[i] : 8'hxx,
                           (i < rx_at.size()) ? rx_at[i] : -1, exp_d[i], exp_t[i]);
      end
    end
    n_checks++;
    if (done_at !== 46 || done_cnt !== 1) begin
      n_fail++; $display("FAIL resp_done: got at=%0d count=%0d want 46 1", done_at, done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int dn;
    cmd0 = 64'h1122334455667788; len0 = 12'd3; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if ({bus0.ntr_clk, bus0.ntr_data_oe, bus0.ntr_data_out} !== {2'b01, 8'h44}) begin
      n_fail++; $display("FAIL midrst_pre: got clk,oe,data=%b,%b,%h want 0,1,44",
                         bus0.ntr_clk, bus0.ntr_data_oe, bus0.ntr_data_out);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus0.ntr_cs1, bus0.ntr_clk, bus0.ntr_data_oe, busy0, done0} !== 5'b11000) begin
      n_fail++; $display("FAIL midrst_state: got cs1,clk,oe,busy,done=%b want 11000",
                         {bus0.ntr_cs1, bus0.ntr_clk, bus0.ntr_data_oe, busy0, done0});
    end
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0) dn++;
    end
    n_checks++;
    if (dn !== 0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_nodone: got done pulses=%0d busy=%b want 0 0", dn, busy0);
    end
    resp_pat.delete();
    resp_pat.push_back(8'h5A);
    run_txn(64'hCAFEF00D12345678, 12'd1, -1, 64'h0);
    n_checks++;
    if (done_at !== 38 || rx_got.size() !== 1 || got_bytes.size() !== 8) begin
      n_fail++; $display("FAIL midrst_after: got done_at=%0d rx=%0d cmd=%0d want 38 1 8",
                         done_at, rx_got.size(), got_bytes.size());
    end
    n_checks++;
    if (rx_got.size() != 1 || rx_got[0] !== 8'h5A || got_bytes.size() != 8 || got_bytes[0] !== 8'hCA) begin
      n_fail++; $display("FAIL midrst_data: got rx=%h first cmd=%h want 5a ca",
                         (rx_got.size() > 0) ? rx_got[0] : 8'hxx,
                         (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx);
    end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] exp_cmd;
    int          bad;
    exp_cmd = 64'h0123456789ABCDEF;
    resp_pat.delete();
    resp_pat.push_back(8'hA5); resp_pat.push_back(8'h5A); resp_pat.push_back(8'hC3);
    run_txn(exp_cmd, 12'd3, 10, 64'hFEDCBA9876543210);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= got_bytes.size() || got_bytes[i] !== exp_cmd[63-8*i -: 8]) bad++;
    end
    n_checks++;
    if (bad !== 0 || got_bytes.size() !== 8) begin
      n_fail++; $display("FAIL busy_cmd: got %0d wrong of %0d bytes want 0 of 8", bad, got_bytes.size());
    end
    n_checks++;
    if (done_cnt !== 1 || done_at !== 46 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL busy_done: got count=%0d at=%0d busy=%b want 1 46 0",
                         done_cnt, done_at, busy0);
    end
  endtask

  task automatic test_back_to_back();
    int got;
    cmd0 = 64'h00FF00FF00FF00FF; len0 = 12'd0; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    got = -1;
    for (int n = 0; n < 100; n++) begin
      if (done0) begin got = n; break; end
      @(negedge clk);
    end
    n_checks++;
    if (got !== 34) begin
      n_fail++; $display("FAIL b2b_first_done: got %0d want 34", got);
    end
    start0 = 1'b1; cmd0 = 64'h8000000000000000;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    n_checks++;
    if ({busy0, bus0.ntr_cs1, done0} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_accept: got busy,cs1,done=%b want 100", {busy0, bus0.ntr_cs1, done0});
    end
    got = -1;
    for (int n = 0; n < 100; n++) begin
      if (done0) begin got = n; break; end
      @(negedge clk);
    end
    n_checks++;
    if (got !== 34) begin
      n_fail++; $display("FAIL b2b_second_done: got %0d want 34", got);
    end
    @(negedge clk);
    n_checks++;
    if ({busy0, done0, bus0.ntr_cs1} !== 3'b001) begin
      n_fail++; $display("FAIL b2b_idle: got busy,done,cs1=%b want 001", {busy0, done0, bus0.ntr_cs1});
    end
  endtask

  task automatic test_clkdiv1();
    run_txn1(12'd1, 200);
    n_checks++;
    if (fall1_at !== 17 + TA || rx1_first !== 18 + TA || done1_at !== 19 + TA) begin
      n_fail++; $display("FAIL div1_timing: got fall=%0d cap=%0d done=%0d want %0d %0d %0d",
                         fall1_at, rx1_first, done1_at, 17 + TA, 18 + TA, 19 + TA);
    end
    n_checks++;
    if (rx1_cnt !== 1 || rx1_first_d !== 8'h3C || done1_cnt !== 1) begin
      n_fail++; $display("FAIL div1_data: got count=%0d data=%h done=%0d want 1 3c 1",
                         rx1_cnt, rx1_first_d, done1_cnt);
    end
  endtask

  task automatic test_max_len();
    run_txn1(12'hFFF, 9000);
    n_checks++;
    if (rx1_cnt !== 4095 || done1_cnt !== 1) begin
      n_fail++; $display("FAIL maxlen_count: got bytes=%0d done=%0d want 4095 1", rx1_cnt, done1_cnt);
    end
    n_checks++;
    if (done1_at !== 8207 + TA || rx1_last_d !== 8'h3A) begin
      n_fail++; $display("FAIL maxlen_end: got done_at=%0d last=%h want %0d 3a",
                         done1_at, rx1_last_d, 8207 + TA);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_only();
    test_resp();
    test_mid_reset();
    test_busy_ignore();
    test_back_to_back();
    test_clkdiv1();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntr_host_ctrl.md
Name: ntr_host_ctrl

Overview:
- NTR (DS card bus) host-side initiator. It is the other end of the card-side command receiver in `top`.
- Generates ntr_clk and ntr_cs1, shifts out an 8-byte command, then clocks in N response bytes from the card.
- Used as the bench/bring-up driver for the card receiver, and as a standalone host on FPGA.

Parameters:
- CLK_DIV, 4, clk cycles per ntr_clk half-period; must be >= 1.
- RESP_LEN_W, 12, width of the response byte count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a transaction; honoured only while busy=0
- cmd_data  in  64  command; byte 0 = cmd_data[63:56], sent first
- resp_len  in  RESP_LEN_W  number of response bytes to read; 0 is legal
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at the end of a transaction
- ntr_clk  out  1  bus clock; idles high
- ntr_cs1  out  1  chip select, active low; idles high
- ntr_data_out  out  8  host drive data
- ntr_data_oe  out  1  host drives ntr_data when 1
- ntr_data_in  in  8  bus data from card
- rx_data  out  8  last captured response byte
- rx_valid  out  1  one-cycle pulse when rx_data updates

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- All outputs are registered.
- Reset values: busy=0, done=0, ntr_clk=1, ntr_cs1=1, ntr_data_out=0x00, ntr_data_oe=0, rx_data=0x00, rx_valid=0.
- FSM states: IDLE, SETUP, CMD_LO, CMD_HI, RSP_LO, RSP_HI, END.
- A phase timer counts CLK_DIV cycles per state, except IDLE and END.
- IDLE:
  - start=1 at edge E0 latches cmd_data and resp_len.
  - busy=1 and ntr_cs1=0 at E0; go to SETUP.
- SETUP:
  - Holds for CLK_DIV cycles.
  - At E0+CLK_DIV: ntr_clk=0, ntr_data_out=byte0, ntr_data_oe=1; go to CMD_LO.
- Command bytes, k = 0..7:
  - ntr_clk falls and data changes at E0+CLK_DIV*(1+2k).
  - ntr_clk rises at E0+CLK_DIV*(2+2k).
  - Data is stable through the whole high phase; the card samples on the rising edge.
- At the end of the CMD_HI phase for k=7 (E0+17*CLK_DIV):
  - ntr_data_oe=0 and ntr_data_out=0x00.
  - resp_len=0: go to END. Otherwise: ntr_clk=0, go to RSP_LO.
- Response bytes, j = 0..resp_len-1:
  - ntr_clk falls at E0+CLK_DIV*(17+2j).
  - ntr_clk rises at E0+CLK_DIV*(18+2j). On that same clk edge, rx_data <= ntr_data_in and rx_valid=1 for one cycle.
- END: at the end of the last high phase:
  - ntr_cs1=1, done=1, busy=0, all in the same edge.
  - Next cycle: done=0, state returns to IDLE.
  - start asserted in the done cycle is accepted at the following edge.
- start while busy=1: ignored; latched cmd_data and resp_len are unaffected.
- resp_len = 2^RESP_LEN_W-1: the down-counter must not wrap early; exactly that many bytes are read.
- rst_n=0 mid-transaction: next edge forces reset values (cs1 high, ntr_clk high, oe low). No done pulse.
- CLK_DIV=1: each half-period is one clk cycle; timing formulas still hold.

Optional Feature:
- NTR_TURNAROUND_EN
- Defined:
  - After the last command byte and before the first response ntr_clk fall, ntr_clk stays high for 2*CLK_DIV extra cycles with oe=0.
  - All response timings shift by +2*CLK_DIV.
  - No turnaround is inserted when resp_len=0.
- Undefined: no gap; timing exactly as above.

Decomposition:
- Shared header ntr_defs.vh:
  - NTR_CMD_BYTES=8
  - FSM state encodings
  - NTR_IDLE_CLK=1'b1, NTR_IDLE_CS=1'b1
- Sub-module ntr_phase_timer:
  - Loadable down-counter of width clog2(CLK_DIV+1).
  - Outputs a one-cycle `expire` pulse; reload on state change.
  - Shared with the card-side receiver for timeout use.

Test Plan (CLK_DIV=2 unless noted):
- Reset, then idle 10 cycles -> ntr_clk=1, ntr_cs1=1, oe=0, busy=0, done=0 throughout.
- start with cmd_data=0xFF00000000000001, resp_len=0 -> 8 rising ntr_clk edges presenting FF,00,00,00,00,00,00,01 with oe=1; cs1 rises and done pulses at E0+34.
- Same command, resp_len=3, card model drives A5,5A,C3 after each ntr_clk fall -> rx_valid pulses 3x with rx_data A5,5A,C3 at E0+36, +40, +44; done at E0+46.
- rst_n=0 during the 4th command byte -> next edge: cs1=1, ntr_clk=1, oe=0, busy=0; no done. A new start afterwards completes normally.
- start pulsed again while busy with a different cmd_data -> the transmitted bytes still match the first command; exactly one done.
- CLK_DIV=1 with NTR_TURNAROUND_EN defined, resp_len=1 -> first response ntr_clk fall at E0+19, capture at E0+20, done at E0+21.
